// File: rtl/peak_pkg.sv
// Shared peak-stage types and widths used by the peak frame FIFO.
package peak_pkg;

  localparam int PEAKS              = 6;
  localparam int FREQ_WIDTH         = 8;
  localparam int FINAL_AMPL_WIDTH   = 16;
  localparam int TIME_COUNTER_WIDTH = 16;
  localparam int INDEX_WIDTH        = 3;

  // One spectral peak: frequency bin and signed amplitude.
  typedef struct packed {
    logic        [FREQ_WIDTH-1:0]       freq;
    logic signed [FINAL_AMPL_WIDTH-1:0] ampl;
  } peak_entry_t;

  // One frame of peaks; 'time' is a keyword, so the stamp is time_stamp.
  typedef struct packed {
    logic [TIME_COUNTER_WIDTH-1:0] time_stamp;
    peak_entry_t [PEAKS-1:0]       entries;
  } peak_frame_t;

  // Read-side sequencer states.
  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/peak_frame_fifo_if.sv
// Serial peak-entry stream: the FIFO is master, the consumer is slave.
interface peak_frame_fifo_if;
  import peak_pkg::*;

  logic                                out_valid;
  logic                                out_ready;
  logic        [FREQ_WIDTH-1:0]        out_freq;
  logic signed [FINAL_AMPL_WIDTH-1:0]  out_ampl;
  logic        [TIME_COUNTER_WIDTH-1:0] out_time;
  logic        [INDEX_WIDTH-1:0]       out_index;
  logic                                out_last;

  modport master (
    output out_valid, out_freq, out_ampl, out_time, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_freq, out_ampl, out_time, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/peak_frame_mem.sv
// Frame storage: DEPTH whole frames, one write port, one read port whose
// address is registered so the read data follows the pointer after an edge.
module peak_frame_mem
  import peak_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  peak_frame_t              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output peak_frame_t              rd_data
);

  peak_frame_t              mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] rd_addr_q;

  // Write a captured frame and register the read address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/peak_frame_fifo.sv
// Frame FIFO for peak-detector results: captures a whole frame of PEAKS
// entries whenever the time stamp changes and streams the oldest frame out
// one entry per handshake.
// Optional build macro PEAK_FIFO_DROP_CNT_EN adds a saturating drop_count.
module peak_frame_fifo
  import peak_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic signed [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0] amplitudes_in,
  input  logic        [PEAKS-1:0][FREQ_WIDTH-1:0]    freqs_in,
  input  logic        [TIME_COUNTER_WIDTH-1:0]       counter_in,
  input  logic                                       flush,
  peak_frame_fifo_if.master                          out_if,
  output logic        [$clog2(DEPTH):0]              frame_count,
  output logic                                       overflow
`ifdef PEAK_FIFO_DROP_CNT_EN
  ,
  output logic        [15:0]                         drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]          FULL_CNT = CW'(DEPTH);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(PEAKS - 1);

  logic [TIME_COUNTER_WIDTH-1:0] last_cnt;
  logic [AW-1:0]                 wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]                 count_nxt;
  rd_state_e                     state_q, state_d;
  logic [INDEX_WIDTH-1:0]        idx_q, idx_d;
  logic                          capture, stream, fire, pop, full, push, drop;
  peak_frame_t                   wr_frame, head_frame;
  peak_entry_t                   head_entry;

  // A pop completing this cycle frees a slot, so it lifts the full condition.
  assign capture = (counter_in != last_cnt);
  assign stream  = (state_q == RD_STREAM);
  assign fire    = stream && out_if.out_ready;
  assign pop     = fire && (idx_q == LAST_IDX);
  assign full    = (frame_count == FULL_CNT) && !pop;
  assign push    = capture && !flush && !full;
  assign drop    = capture && !flush && full;

  assign rd_ptr_nxt = flush ? '0 : (pop ? rd_ptr + AW'(1) : rd_ptr);

  // Occupancy after this edge, ignoring flush.
  always_comb begin
    count_nxt = frame_count;
    if (push && !pop) begin
      count_nxt = frame_count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = frame_count - CW'(1);
    end
  end

  // Pack the incoming peak vectors into one frame word.
  always_comb begin
    wr_frame            = '0;
    wr_frame.time_stamp = counter_in;
    for (int i = 0; i < PEAKS; i++) begin
      wr_frame.entries[i].freq = freqs_in[i];
      wr_frame.entries[i].ampl = amplitudes_in[i];
    end
  end

  peak_frame_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_frame),
    .rd_addr (rd_ptr_nxt),
    .rd_data (head_frame)
  );

  // Time-stamp history, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      last_cnt <= counter_in;
      rd_ptr   <= rd_ptr_nxt;
      if (flush) begin
        wr_ptr      <= '0;
        frame_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        frame_count <= count_nxt;
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Read sequencer state and entry index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RD_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: stream the head frame entry by entry, chaining straight into
  // the next stored frame after the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RD_IDLE: begin
        idx_d = '0;
        if (frame_count != '0) begin
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (count_nxt == '0) begin
              state_d = RD_IDLE;
            end
          end else begin
            idx_d = idx_q + INDEX_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
        idx_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = RD_IDLE;
      idx_d   = '0;
    end
  end

  assign head_entry = head_frame.entries[idx_q];

  // Present the current entry; outputs are forced to zero outside STREAM.
  always_comb begin
    out_if.out_valid = 1'b0;
    out_if.out_freq  = '0;
    out_if.out_ampl  = '0;
    out_if.out_time  = '0;
    out_if.out_last  = 1'b0;
    out_if.out_index = idx_q;
    if (stream) begin
      out_if.out_valid = 1'b1;
      out_if.out_freq  = head_entry.freq;
      out_if.out_ampl  = head_entry.ampl;
      out_if.out_time  = head_frame.time_stamp;
      out_if.out_last  = (idx_q == LAST_IDX);
    end
  end

`ifdef PEAK_FIFO_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count dropped frames, holding at the maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (flush) begin
      drop_count <= '0;
    end else if (drop) begin
      drop_count <= sat_inc16(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_peak_frame_fifo.sv
// Bench for peak_frame_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_peak_frame_fifo;
  import peak_pkg::*;

  localparam int DEPTH = 8;

  logic                                        clk = 1'b0;
  logic                                        reset;
  logic                                        flush;
  logic                                        rdy;
  logic        [TIME_COUNTER_WIDTH-1:0]        cnt_in;
  logic        [PEAKS-1:0][FREQ_WIDTH-1:0]     freq_in;
  logic signed [PEAKS-1:0][FINAL_AMPL_WIDTH-1:0] ampl_in;
  logic        [$clog2(DEPTH):0]               fc;
  logic                                        ovf;
`ifdef PEAK_FIFO_DROP_CNT_EN
  logic        [15:0]                          dc;
`endif

  peak_frame_fifo_if bus ();
  assign bus.out_ready = rdy;

  peak_frame_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .amplitudes_in (ampl_in),
    .freqs_in      (freq_in),
    .counter_in    (cnt_in),
    .flush         (flush),
    .out_if        (bus.master),
    .frame_count   (fc),
    .overflow      (ovf)
`ifdef PEAK_FIFO_DROP_CNT_EN
    ,
    .drop_count    (dc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  peak_frame_t q[$];
  bit          m_valid;
  int          m_idx;
  bit          m_ovf;
  int          m_drops;
  logic [TIME_COUNTER_WIDTH-1:0] m_last;

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_idx = 0; m_ovf = 0; m_drops = 0; m_last = '0;
  endtask

  task automatic model_step();
    bit cap, fire, popf, pushf;
    int sz;
    peak_frame_t f;
    cap   = (cnt_in != m_last);
    fire  = m_valid && rdy;
    popf  = fire && (m_idx == PEAKS - 1);
    sz    = q.size();
    pushf = cap && !flush && !(sz == DEPTH && !popf);
    m_last = cnt_in;
    if (flush) begin
      q.delete();
      m_valid = 0; m_idx = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    if (cap && !pushf) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end
    if (popf) void'(q.pop_front());
    if (pushf) begin
      f.time_stamp = cnt_in;
      for (int i = 0; i < PEAKS; i++) begin
        f.entries[i].freq = freq_in[i];
        f.entries[i].ampl = ampl_in[i];
      end
      q.push_back(f);
    end
    if (!m_valid) begin
      m_valid = (sz != 0);
    end else if (fire) begin
      if (popf) begin
        m_idx   = 0;
        m_valid = (q.size() != 0);
      end else begin
        m_idx++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  task automatic compare();
    check("m_valid", bus.out_valid, m_valid);
    check("m_count", fc, q.size());
    check("m_overflow", ovf, m_ovf);
`ifdef PEAK_FIFO_DROP_CNT_EN
    check("m_drop_count", dc, m_drops);
`endif
    if (m_valid) begin
      if (q.size() == 0) begin
        check("m_queue_nonempty", 0, 1);
      end else begin
        check("m_freq", bus.out_freq, q[0].entries[m_idx].freq);
        check("m_ampl", bus.out_ampl, q[0].entries[m_idx].ampl);
        check("m_time", bus.out_time, q[0].time_stamp);
        check("m_index", bus.out_index, m_idx);
        check("m_last", bus.out_last, m_idx == PEAKS - 1);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) compare();
  end

  // ---------------- transfer log ----------------
  typedef struct {
    int f;
    int a;
    int t;
    int i;
    bit last;
  } xfer_t;
  xfer_t xlog[$];

  initial forever begin
    xfer_t x;
    @(negedge clk);
    if (!reset && bus.out_valid && rdy) begin
      x.f = bus.out_freq; x.a = bus.out_ampl; x.t = bus.out_time;
      x.i = bus.out_index; x.last = bus.out_last;
      xlog.push_back(x);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input int t);
    cnt_in = TIME_COUNTER_WIDTH'(t);
    for (int i = 0; i < PEAKS; i++) begin
      freq_in[i] = FREQ_WIDTH'(t * 10 + i);
      ampl_in[i] = FINAL_AMPL_WIDTH'(-(t * 100) + i * 7);
    end
  endtask

  task automatic do_reset();
    reset = 1; flush = 0; rdy = 0; cnt_in = '0;
    repeat (2) tick();
    reset = 0;
    tick();
  endtask

  task automatic wait_index(input int idx);
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.out_valid && bus.out_index == idx) begin ok = 1; break; end
    end
    check("wait_index_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!bus.out_valid && fc == 0) begin ok = 1; break; end
    end
    check("wait_idle_timeout", ok, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int f1[PEAKS] = '{3, 20, 40, 70, 110, 200};
  int a1[PEAKS] = '{-100, -50, 0, 25, 32767, -32768};

  initial begin
    reset = 1; flush = 0; rdy = 0; cnt_in = '0; freq_in = '0; ampl_in = '0;
    repeat (3) tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_count", fc, 0);
    check("rst_overflow", ovf, 0);
    check("rst_freq", bus.out_freq, 0);
    check("rst_ampl", bus.out_ampl, 0);
    check("rst_time", bus.out_time, 0);
    check("rst_index", bus.out_index, 0);
    check("rst_last", bus.out_last, 0);
    reset = 0;
    repeat (2) tick();
    check("idle_no_capture", fc, 0);

    // Single frame with latency check.
    rdy = 1;
    xlog.delete();
    cnt_in = 1;
    for (int i = 0; i < PEAKS; i++) begin
      freq_in[i] = FREQ_WIDTH'(f1[i]);
      ampl_in[i] = FINAL_AMPL_WIDTH'(a1[i]);
    end
    @(negedge clk); check("lat_n_valid", bus.out_valid, 0);
    @(negedge clk); check("lat_n1_valid", bus.out_valid, 0);
    check("lat_n1_count", fc, 1);
    @(negedge clk); check("lat_n2_valid", bus.out_valid, 1);
    wait_idle();
    check("single_xfers", xlog.size(), PEAKS);
    if (xlog.size() == PEAKS) begin
      for (int i = 0; i < PEAKS; i++) begin
        check("single_freq", xlog[i].f, f1[i]);
        check("single_index", xlog[i].i, i);
        check("single_last", xlog[i].last, i == PEAKS - 1);
        check("single_time", xlog[i].t, 1);
      end
      check("single_ampl0", xlog[0].a, -100);
      check("single_ampl5", xlog[5].a, -32768);
    end

    // Backpressure at index 2.
    xlog.delete();
    load_pattern(2);
    wait_index(2);
    rdy = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_index", bus.out_index, 2);
      check("bp_freq", bus.out_freq, 22);
      check("bp_ampl", bus.out_ampl, -186);
      check("bp_time", bus.out_time, 2);
    end
    rdy = 1;
    wait_idle();
    check("bp_xfers", xlog.size(), PEAKS);
    for (int i = 0; i < xlog.size(); i++) check("bp_seq", xlog[i].i, i);

    // Overflow: nine frames into a stalled FIFO of eight.
    do_reset();
    for (int t = 1; t <= 9; t++) begin
      load_pattern(t);
      tick();
    end
    tick();
    check("ovf_count", fc, 8);
    check("ovf_flag", ovf, 1);
`ifdef PEAK_FIFO_DROP_CNT_EN
    check("ovf_drop_count", dc, 1);
`endif
    xlog.delete();
    rdy = 1;
    wait_idle();
    check("ovf_xfers", xlog.size(), 8 * PEAKS);
    if (xlog.size() == 8 * PEAKS)
      for (int f = 0; f < 8; f++) check("ovf_time", xlog[f * PEAKS].t, f + 1);

    // Full with a simultaneous pop: capture coincides with the last transfer.
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      load_pattern(t);
      tick();
    end
    tick();
    check("fp_count_before", fc, 8);
    xlog.delete();
    rdy = 1;
    wait_index(5);
    load_pattern(20);
    tick();
    check("fp_count_after", fc, 8);
    check("fp_overflow", ovf, 0);
    wait_idle();
    check("fp_xfers", xlog.size(), 9 * PEAKS);
    if (xlog.size() == 9 * PEAKS) begin
      check("fp_time_second", xlog[PEAKS].t, 2);
      check("fp_time_new", xlog[8 * PEAKS].t, 20);
      check("fp_freq_new", xlog[8 * PEAKS + 3].f, 203);
    end

    // Flush mid-stream, with a capture in the same cycle that must be ignored.
    do_reset();
    rdy = 1;
    load_pattern(1);
    wait_index(3);
    flush = 1;
    load_pattern(5);
    tick();
    flush = 0;
    check("fl_valid", bus.out_valid, 0);
    check("fl_count", fc, 0);
    repeat (3) tick();
    check("fl_no_capture", fc, 0);
    check("fl_idle", bus.out_valid, 0);
    xlog.delete();
    load_pattern(6);
    wait_idle();
    check("fl_xfers", xlog.size(), PEAKS);
    if (xlog.size() == PEAKS) begin
      check("fl_first_index", xlog[0].i, 0);
      check("fl_time", xlog[0].t, 6);
      check("fl_last", xlog[5].last, 1);
    end

    // Reset mid-stream.
    load_pattern(7);
    wait_index(3);
    reset = 1;
    cnt_in = '0;
    #1;
    check("rs_valid", bus.out_valid, 0);
    check("rs_count", fc, 0);
    repeat (2) tick();
    reset = 0;
    repeat (3) tick();
    check("rs_no_capture", fc, 0);
    xlog.delete();
    load_pattern(1);
    wait_idle();
    check("rs_xfers", xlog.size(), PEAKS);
    if (xlog.size() == PEAKS) begin
      check("rs_first_index", xlog[0].i, 0);
      check("rs_time", xlog[0].t, 1);
      check("rs_freq0", xlog[0].f, 10);
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
